// File: rtl/ram_stream_tx.sv
// ram_stream_tx
// Reads one frame of 1..64 words from a source RAM (one-cycle read latency)
// and sends it as a valid/ready stream. The last word carries tlast. A
// 2-entry skid FIFO absorbs the read latency, so backpressure never drops or
// duplicates a word.
//
// Optional feature: define STREAM_TX_HDR_EN to put one header word
// {16'hA5A5, o_frame_cnt, 9'd0, len_q, 16'd0} in front of every frame.
//
// Ports
//   clk_50m      system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      one-cycle frame request, sampled in IDLE only
//   i_frame_len  frame length in words; 0 or >64 means 64
//   o_busy       high from the start edge until the tlast handshake
//   o_done       one-cycle pulse after the tlast handshake
//   o_frame_cnt  completed frame count, wraps at 16 bits
//   src_rd_en    source RAM read enable
//   src_rd_addr  source RAM read address
//   src_rd_data  source RAM data, valid the cycle after src_rd_en
//   data_en      stream valid
//   data_out     stream data
//   o_tlast      last word of the frame
//   i_ready      downstream ready
module ram_stream_tx #(
  parameter int DW    = 64,
  parameter int AW    = 6,
  parameter int LEN_W = 7
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_frame_cnt,
  output logic             src_rd_en,
  output logic [AW-1:0]    src_rd_addr,
  input  logic [DW-1:0]    src_rd_data,
  output logic             data_en,
  output logic [DW-1:0]    data_out,
  output logic             o_tlast,
  input  logic             i_ready
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**AW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] clamped_len;
  logic             inflight;
  logic             inflight_last;
  logic             hdr_pend;
  logic             pop;
  logic             push;
  logic [DW-1:0]    push_data;
  logic             push_last;
  logic [2:0]       occ;
  logic             tail_valid;
  logic [DW-1:0]    tail_data;
  logic             tail_last;

  // The FIFO head is the output register set itself: data_en/data_out/o_tlast.
  assign pop = data_en && i_ready;
  assign clamped_len = ((i_frame_len == '0) || (i_frame_len > MAX_LEN)) ? MAX_LEN : i_frame_len;

  // Slots committed: buffered words, the read in flight and a pending header.
  assign occ = {2'b00, data_en} + {2'b00, tail_valid} + {2'b00, inflight} + {2'b00, hdr_pend};

  // The pop happening this cycle frees a slot, which keeps one word per cycle
  // flowing with i_ready high while never committing more than two slots.
  assign src_rd_en = (state == RUN) && (rd_cnt < len_q) && (occ < (3'd2 + {2'b00, pop}));

  assign push      = inflight || hdr_pend;
  assign push_last = hdr_pend ? 1'b0 : inflight_last;

`ifdef STREAM_TX_HDR_EN
  // Header is pending only in the first RUN cycle and enters the FIFO at E1.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      hdr_pend <= 1'b0;
    end else begin
      hdr_pend <= (state == IDLE) && i_start;
    end
  end
  assign push_data = hdr_pend ? DW'({16'hA5A5, o_frame_cnt, 9'd0, len_q, 16'd0}) : src_rd_data;
`else
  assign hdr_pend  = 1'b0;
  assign push_data = src_rd_data;
`endif

  // Frame control: length latch, read issue counters and completion bookkeeping.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      len_q         <= '0;
      rd_cnt        <= '0;
      src_rd_addr   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_done        <= 1'b0;
      inflight      <= src_rd_en;
      inflight_last <= src_rd_en && (rd_cnt == (len_q - LEN_W'(1)));
      if (src_rd_en) begin
        rd_cnt      <= rd_cnt + LEN_W'(1);
        src_rd_addr <= src_rd_addr + AW'(1);
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state       <= RUN;
            len_q       <= clamped_len;
            rd_cnt      <= '0;
            src_rd_addr <= '0;
            o_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (pop && o_tlast) begin
            state       <= DONE;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            o_frame_cnt <= o_frame_cnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO: head drives the stream outputs, tail catches the
  // word that returns while the head is stalled.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      data_en    <= 1'b0;
      data_out   <= '0;
      o_tlast    <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (tail_valid) begin
            data_out  <= tail_data;
            o_tlast   <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end else begin
            data_out <= push_data;
            o_tlast  <= push_last;
          end
        end
        2'b01: begin
          if (tail_valid) begin
            data_out   <= tail_data;
            o_tlast    <= tail_last;
            tail_valid <= 1'b0;
          end else begin
            data_en  <= 1'b0;
            data_out <= '0;
            o_tlast  <= 1'b0;
          end
        end
        2'b10: begin
          if (!data_en) begin
            data_en  <= 1'b1;
            data_out <= push_data;
            o_tlast  <= push_last;
          end else begin
            tail_valid <= 1'b1;
            tail_data  <= push_data;
            tail_last  <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
